// File: rtl/choose_lift_pkg.sv
// rtl/choose_lift_pkg.sv - shared widths, encodings and helpers for the two-car dispatch arbiter
package choose_lift_pkg;

  localparam int FLOOR_W    = 3;
  localparam int NUM_FLOORS = 8;
  localparam int COST_W     = FLOOR_W + 1;

  typedef logic [FLOOR_W-1:0] floor_t;
  typedef logic [COST_W-1:0]  cost_t;

  localparam logic [1:0] LIFT_NONE = 2'b00;
  localparam logic [1:0] LIFT_1    = 2'b01;
  localparam logic [1:0] LIFT_2    = 2'b10;

  // Distance between two floors, widened so sums of two distances cannot wrap
  function automatic cost_t abs_diff(input floor_t a, input floor_t b);
    return (a >= b) ? cost_t'(a - b) : cost_t'(b - a);
  endfunction

  // Compared at cost width so the check stays meaningful when NUM_FLOORS == 2**FLOOR_W
  function automatic logic out_of_range(input floor_t f);
    return cost_t'(f) >= cost_t'(NUM_FLOORS);
  endfunction

endpackage

// File: rtl/choose_lift_if.sv
// rtl/choose_lift_if.sv - car state, hall request and dispatch result bundle
interface choose_lift_if;
  import choose_lift_pkg::*;

  floor_t     lift1_floor;
  floor_t     lift1_md;
  logic       lift1_im;
  floor_t     lift2_floor;
  floor_t     lift2_md;
  logic       lift2_im;
  floor_t     req_floor;
  logic       req_valid;
  logic [1:0] chosen_lift;
  logic       chosen_valid;

  modport master (
    output lift1_floor, lift1_md, lift1_im,
    output lift2_floor, lift2_md, lift2_im,
    output req_floor, req_valid,
    input  chosen_lift, chosen_valid
  );

  modport slave (
    input  lift1_floor, lift1_md, lift1_im,
    input  lift2_floor, lift2_md, lift2_im,
    input  req_floor, req_valid,
    output chosen_lift, chosen_valid
  );

endinterface

// File: rtl/choose_lift_lift_cost.sv
// rtl/choose_lift_lift_cost.sv - cost for one car to serve a hall request
module lift_cost
  import choose_lift_pkg::*;
(
  input  floor_t floor,
  input  floor_t md,
  input  logic   im,
  input  floor_t req,
  output cost_t  cost,
  output logic   range_err
);

  logic going_up;
  logic going_down;
  logic on_path;

  // On-path cost equals the plain distance, so idle and on-path share one branch;
  // a moving car sitting at req is departing and takes the detour cost
  always_comb begin
    going_up   = im && (md > floor);
    going_down = im && (md < floor);
    on_path    = (going_up && (req > floor) && (req <= md)) ||
                 (going_down && (req >= md) && (req < floor));
    if (!going_up && !going_down) begin
      cost = abs_diff(req, floor);
    end else if (on_path) begin
      cost = abs_diff(req, floor);
    end else begin
      cost = abs_diff(md, floor) + abs_diff(md, req);
    end
    range_err = out_of_range(floor) || out_of_range(md);
  end

endmodule

// File: rtl/choose_lift.sv
// rtl/choose_lift.sv - picks the cheaper car for each hall request, registered result
module choose_lift
  import choose_lift_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  choose_lift_if.slave bus
);

  cost_t      cost1;
  cost_t      cost2;
  logic       err1;
  logic       err2;
  logic [1:0] chosen_lift_d;
  logic [1:0] chosen_lift_q;
  logic       chosen_valid_d;
  logic       chosen_valid_q;

  lift_cost u_cost1 (
    .floor     (bus.lift1_floor),
    .md        (bus.lift1_md),
    .im        (bus.lift1_im),
    .req       (bus.req_floor),
    .cost      (cost1),
    .range_err (err1)
  );

  lift_cost u_cost2 (
    .floor     (bus.lift2_floor),
    .md        (bus.lift2_md),
    .im        (bus.lift2_im),
    .req       (bus.req_floor),
    .cost      (cost2),
    .range_err (err2)
  );

  // Car 2 wins only on strictly lower cost; idle cycles hold the last choice
  always_comb begin
    chosen_lift_d  = chosen_lift_q;
    chosen_valid_d = 1'b0;
    if (bus.req_valid) begin
      chosen_valid_d = 1'b1;
      if (err1 || err2 || out_of_range(bus.req_floor)) begin
        chosen_lift_d = LIFT_NONE;
      end else if (cost2 < cost1) begin
        chosen_lift_d = LIFT_2;
      end else begin
        chosen_lift_d = LIFT_1;
      end
    end
  end

  // Output register stage; reset discards any request in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chosen_lift_q  <= LIFT_NONE;
      chosen_valid_q <= 1'b0;
    end else begin
      chosen_lift_q  <= chosen_lift_d;
      chosen_valid_q <= chosen_valid_d;
    end
  end

  assign bus.chosen_lift  = chosen_lift_q;
  assign bus.chosen_valid = chosen_valid_q;

endmodule

// File: tb/tb_choose_lift.sv
// tb/tb_choose_lift.sv - scoreboard bench for the two-car dispatch arbiter
module tb_choose_lift;
  import choose_lift_pkg::*;

  typedef struct {
    logic       v;
    logic [1:0] lift;
    int         cyc;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic [1:0] last_lift = LIFT_NONE;
  exp_t sb[$];

  choose_lift_if bus ();

  choose_lift dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: each queued expectation falls due at the negedge after its sampling edge
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc + 1 == cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (bus.chosen_valid !== e.v || bus.chosen_lift !== e.lift) begin
        n_bad++;
        $display("FAIL %s: got valid=%b lift=%b, want valid=%b lift=%b",
                 e.name, bus.chosen_valid, bus.chosen_lift, e.v, e.lift);
      end
    end else if (bus.chosen_valid === 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_pulse: got valid=%b lift=%b, want valid=0",
               bus.chosen_valid, bus.chosen_lift);
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want summary");
    $fatal(1, "timeout");
  end

  task automatic set_cars(input floor_t f1, input floor_t m1, input logic i1,
                          input floor_t f2, input floor_t m2, input logic i2);
    bus.lift1_floor = f1; bus.lift1_md = m1; bus.lift1_im = i1;
    bus.lift2_floor = f2; bus.lift2_md = m2; bus.lift2_im = i2;
  endtask

  task automatic req(input string name, input floor_t r, input logic [1:0] exp_lift);
    exp_t e;
    bus.req_floor = r;
    bus.req_valid = 1'b1;
    e.v = 1'b1; e.lift = exp_lift; e.cyc = cyc; e.name = name;
    sb.push_back(e);
    last_lift = exp_lift;
    @(posedge clk); #2;
  endtask

  task automatic idle(input string name);
    exp_t e;
    bus.req_valid = 1'b0;
    e.v = 1'b0; e.lift = last_lift; e.cyc = cyc; e.name = name;
    sb.push_back(e);
    @(posedge clk); #2;
  endtask

  task automatic chk_now(input string name, input logic v, input logic [1:0] l);
    n_vec++;
    if (bus.chosen_valid !== v || bus.chosen_lift !== l) begin
      n_bad++;
      $display("FAIL %s: got valid=%b lift=%b, want valid=%b lift=%b",
               name, bus.chosen_valid, bus.chosen_lift, v, l);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_floor = '0;
    set_cars(0, 0, 0, 0, 0, 0);
    #1;
    chk_now("reset_state", 1'b0, LIFT_NONE);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    set_cars(2, 5, 1, 4, 5, 0); req("tie_up_path", 3, LIFT_1);
    set_cars(0, 7, 1, 6, 6, 0); req("idle_closer", 5, LIFT_2);
    set_cars(4, 7, 1, 7, 7, 0); req("behind_detour", 2, LIFT_2);
    set_cars(6, 1, 1, 0, 0, 0); req("tie_down_path", 3, LIFT_1);
    idle("idle_hold_1");
    idle("idle_hold_2");
    set_cars(0, 0, 0, 7, 7, 0); req("b2b_low", 1, LIFT_1);
    req("b2b_high", 6, LIFT_2);
    set_cars(3, 6, 1, 0, 0, 0); req("departing_at_req", 3, LIFT_2);
    set_cars(6, 2, 1, 7, 7, 0); req("down_req_at_md", 2, LIFT_1);
    set_cars(5, 5, 1, 0, 0, 0); req("moving_md_eq_floor", 1, LIFT_2);
    set_cars(0, 7, 1, 7, 7, 0); req("max_detour", 0, LIFT_2);
    set_cars(0, 0, 0, 1, 6, 1); req("car2_detour", 7, LIFT_2);
    set_cars(3, 3, 0, 5, 2, 1); req("car2_down_tie", 4, LIFT_1);
    idle("idle_before_reset");

    // Request presented, then reset asserted before its sampling edge
    set_cars(0, 0, 0, 7, 7, 0);
    bus.req_floor = 6;
    bus.req_valid = 1'b1;
    #4;
    rst_n = 1'b0;
    #1;
    chk_now("async_reset_clears", 1'b0, LIFT_NONE);
    @(posedge clk); #2;
    chk_now("reset_drops_inflight", 1'b0, LIFT_NONE);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    last_lift = LIFT_NONE;
    @(posedge clk); #2;
    req("first_after_reset", 6, LIFT_2);
    idle("idle_after_reset");

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
